// File: rtl/msh_drbg_pkg.sv
// Shared types and constants for the master/slave hash DRBG: FSM states, widths,
// single-block SHA-256 padding and the SHA-256 round constants.
package msh_drbg_pkg;

  localparam int HASH_W = 256;
  localparam int CNT_W  = 64;

  // 0x80 terminator, zero fill, then the 64-bit message length (256 bits)
  localparam logic [255:0] PAD_256 = {1'b1, 191'd0, 64'd256};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_ENTROPY,
    ST_SEED_HASH,
    ST_READY,
    ST_BITS_HASH,
    ST_ACK
  } drbg_state_e;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/master_slave_hash_drbg_sha256.sv
// Iterative SHA-256 of one pre-padded 256-bit message: one round per clock,
// digest and a one-cycle done pulse 64 clocks after start.
module sha256_block
  import msh_drbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HASH_W-1:0] msg,
  output logic              busy,
  output logic              done,
  output logic [HASH_W-1:0] digest
);

  logic [511:0] block;
  logic [31:0]  w [16];
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [5:0]   round;
  logic [31:0]  t1, t2, w_new;

  assign block = {msg, PAD_256};

  // NOTE: every always_comb output is fully assigned on every path, so no latch is inferred.
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[round] + w[0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // NOTE: non-blocking assignments throughout, so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      round  <= '0;
      digest <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      // NOTE: the 16-word schedule window is plain flops, so it is cleared with everything else.
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
        {a, b, c, d, e, f, g, h} <= SHA_IV;
        round <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
        {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
        round <= round + 6'd1;
        if (round == 6'd63) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          digest <= {SHA_IV[255:224] + t1 + t2, SHA_IV[223:192] + a,
                     SHA_IV[191:160] + b,       SHA_IV[159:128] + c,
                     SHA_IV[127:96]  + d + t1,  SHA_IV[95:64]   + e,
                     SHA_IV[63:32]   + f,       SHA_IV[31:0]    + g};
        end
      end
    end
  end

endmodule

// File: rtl/master_slave_hash_drbg.sv
// Two-level hash DRBG: seed chain V_s feeds bits chain V_b through one shared SHA-256 core.
// MSH_DRBG_CATCH_UP_EN enables slave catch-up (blocks generated and dropped without a request).
module master_slave_hash_drbg
  import msh_drbg_pkg::*;
#(
  parameter int SEED_GENERATOR_MAX_CYCLE = 3,
  parameter int BITS_GENERATOR_MAX_CYCLE = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              is_master_mode,
  input  logic              next_seed,
  input  logic              next_bits,
  input  logic              catch_up_mode,
  input  logic [HASH_W-1:0] entropy,
  output logic              init_ready,
  output logic              next_bits_ready,
  output logic [HASH_W-1:0] random_bits,
  output logic [CNT_W-1:0]  reseed_counter
);

  drbg_state_e       state, state_nxt;
  logic [HASH_W-1:0] v_s, v_b, hash_msg, hash_digest;
  logic [CNT_W-1:0]  seed_cnt, bits_cnt;
  logic              reseed_pend, reseed_req, next_seed_act, catch_up_act;
  logic              hash_start, hash_busy, hash_done, seed_entry;

`ifdef MSH_DRBG_CATCH_UP_EN
  assign catch_up_act = catch_up_mode & ~is_master_mode;
`else
  logic unused_catch_up;
  assign unused_catch_up = catch_up_mode;
  assign catch_up_act    = 1'b0;
`endif

  assign next_seed_act   = next_seed & ~is_master_mode;
  assign reseed_req      = reseed_pend | next_seed_act;
  assign seed_entry      = (state_nxt == ST_SEED_HASH) && (state != ST_SEED_HASH);
  assign next_bits_ready = (state == ST_ACK);

  sha256_block u_sha (
    .clk    (clk),
    .rst_n  (reset_n),
    .start  (hash_start & ~hash_busy),
    .msg    (hash_msg),
    .busy   (hash_busy),
    .done   (hash_done),
    .digest (hash_digest)
  );

  always_comb begin
    state_nxt  = state;
    hash_start = 1'b0;
    hash_msg   = v_s;
    case (state)
      ST_IDLE: state_nxt = ST_LOAD_ENTROPY;
      ST_LOAD_ENTROPY: begin
        // V_s is loaded on this same edge, so the seed hash reads entropy directly
        state_nxt  = ST_SEED_HASH;
        hash_start = 1'b1;
        hash_msg   = entropy;
      end
      ST_SEED_HASH: if (hash_done) state_nxt = ST_READY;
      ST_READY: begin
        if (reseed_req) begin
          state_nxt  = ST_SEED_HASH;
          hash_start = 1'b1;
        end else if (next_bits || catch_up_act) begin
          state_nxt  = ST_BITS_HASH;
          hash_start = 1'b1;
          hash_msg   = v_b;
        end
      end
      ST_BITS_HASH: if (hash_done) state_nxt = ST_ACK;
      ST_ACK: begin
        if (!next_bits || catch_up_act) begin
          if (reseed_req) begin
            state_nxt  = ST_SEED_HASH;
            hash_start = 1'b1;
          end else if (bits_cnt >= CNT_W'(BITS_GENERATOR_MAX_CYCLE)) begin
            if (seed_cnt >= CNT_W'(SEED_GENERATOR_MAX_CYCLE)) begin
              state_nxt = ST_LOAD_ENTROPY;
            end else begin
              state_nxt  = ST_SEED_HASH;
              hash_start = 1'b1;
            end
          end else begin
            state_nxt = ST_READY;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      v_s            <= '0;
      v_b            <= '0;
      seed_cnt       <= '0;
      bits_cnt       <= '0;
      reseed_pend    <= 1'b0;
      init_ready     <= 1'b0;
      random_bits    <= '0;
      reseed_counter <= '0;
    end else begin
      state <= state_nxt;
      // a pulse seen during a hash waits here until a reseed actually starts
      if (seed_entry)         reseed_pend <= 1'b0;
      else if (next_seed_act) reseed_pend <= 1'b1;
      if (seed_entry || state_nxt == ST_LOAD_ENTROPY) init_ready <= 1'b0;
      if (state == ST_LOAD_ENTROPY) begin
        v_s      <= entropy;
        seed_cnt <= '0;
      end
      if (state == ST_SEED_HASH && hash_done) begin
        v_b            <= hash_digest;
        v_s            <= v_s + hash_digest + HASH_W'(seed_cnt);
        seed_cnt       <= seed_cnt + CNT_W'(1);
        bits_cnt       <= '0;
        reseed_counter <= reseed_counter + CNT_W'(1);
        init_ready     <= 1'b1;
      end
      if (state == ST_BITS_HASH && hash_done) begin
        random_bits <= hash_digest;
        v_b         <= v_b + hash_digest + HASH_W'(1);
        bits_cnt    <= bits_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_master_slave_hash_drbg.sv
// Directed bench for master_slave_hash_drbg against a behavioural SHA-256 DRBG model.
module tb_master_slave_hash_drbg;
  import msh_drbg_pkg::*;

  localparam int L    = 65;
  localparam int SMAX = 3;
  localparam int BMAX = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         is_master_mode = 1'b0;
  logic         next_seed = 1'b0;
  logic         next_bits = 1'b0;
  logic         catch_up_mode = 1'b0;
  logic [255:0] entropy = '0;
  logic         init_ready, next_bits_ready;
  logic [255:0] random_bits;
  logic [63:0]  reseed_counter;

  int vectors = 0;
  int miscompares = 0;
  int init_rises = 0;
  int rise_base = 0;

  logic [255:0] m_vs, m_vb, m_last;
  logic [63:0]  m_seed_cnt, m_bits_cnt, m_reseed;

  always #5 clk = ~clk;
  always @(posedge init_ready) init_rises <= init_rises + 1;

  master_slave_hash_drbg #(
    .SEED_GENERATOR_MAX_CYCLE(SMAX),
    .BITS_GENERATOR_MAX_CYCLE(BMAX)
  ) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .is_master_mode  (is_master_mode),
    .next_seed       (next_seed),
    .next_bits       (next_bits),
    .catch_up_mode   (catch_up_mode),
    .entropy         (entropy),
    .init_ready      (init_ready),
    .next_bits_ready (next_bits_ready),
    .random_bits     (random_bits),
    .reseed_counter  (reseed_counter)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_block(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    s = hv;
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + SHA_K[t] + w[t];
      t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    return {hv[0] + s[0], hv[1] + s[1], hv[2] + s[2], hv[3] + s[3],
            hv[4] + s[4], hv[5] + s[5], hv[6] + s[6], hv[7] + s[7]};
  endfunction

  function automatic logic [255:0] h_msg(input logic [255:0] x);
    return sha_block({x, 8'h80, 184'd0, 64'd256});
  endfunction

  task automatic m_reset();
    m_vs = '0; m_vb = '0; m_last = '0;
    m_seed_cnt = '0; m_bits_cnt = '0; m_reseed = '0;
  endtask

  task automatic m_load();
    m_vs = entropy;
    m_seed_cnt = '0;
  endtask

  task automatic m_seed();
    logic [255:0] s;
    s = h_msg(m_vs);
    m_vb = s;
    m_vs = m_vs + s + 256'(m_seed_cnt);
    m_seed_cnt++;
    m_bits_cnt = '0;
    m_reseed++;
  endtask

  task automatic m_block();
    m_last = h_msg(m_vb);
    m_vb = m_vb + m_last + 256'd1;
    m_bits_cnt++;
  endtask

  task automatic m_after_ack(input bit forced);
    if (forced || m_bits_cnt >= 64'(BMAX)) begin
      if (!forced && m_seed_cnt >= 64'(SMAX)) m_load();
      m_seed();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_init_ready"}, 256'(init_ready), 256'd0);
    check({tag, "_nb_ready"}, 256'(next_bits_ready), 256'd0);
    check({tag, "_random_bits"}, random_bits, 256'd0);
    check({tag, "_reseed_cnt"}, 256'(reseed_counter), 256'd0);
  endtask

  task automatic do_reset(input string tag, input bit master, input logic [255:0] ent);
    @(negedge clk);
    reset_n = 1'b0;
    next_bits = 1'b0; next_seed = 1'b0; catch_up_mode = 1'b0;
    is_master_mode = master;
    entropy = ent;
    #1;
    check_zero(tag);
    rise_base = init_rises;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset(); m_load(); m_seed();
  endtask

  task automatic wait_init(input string tag, output int cyc);
    cyc = 0;
    while (!init_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_init_wait"}, 256'(init_ready), 256'd1);
  endtask

  task automatic get_block(input string tag, input bit mid_seed);
    int cyc;
    bit forced;
    wait_init(tag, cyc);
    forced = mid_seed && !is_master_mode;
    @(negedge clk);
    next_bits = 1'b1;
    cyc = 0;
    while (!next_bits_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
      next_seed = (mid_seed && cyc == 10);
    end
    next_seed = 1'b0;
    check({tag, "_ack"}, 256'(next_bits_ready), 256'd1);
    check({tag, "_ack_latency"}, 256'(cyc), 256'(L + 1));
    m_block();
    check({tag, "_bits"}, random_bits, m_last);
    check({tag, "_reseed_cnt"}, 256'(reseed_counter), 256'(m_reseed));
    next_bits = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (next_bits_ready && cyc < 10);
    check({tag, "_ack_drop"}, 256'(next_bits_ready), 256'd0);
    m_after_ack(forced);
  endtask

  initial begin
    int cyc;
    int cnt;

    check("model_kat_abc", sha_block({24'h616263, 8'h80, 416'd0, 64'd24}),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // slave, entropy 0: nine blocks over three seeds, then re-ingest of changed entropy
    do_reset("s1_rst", 1'b0, 256'd0);
    wait_init("s1", cyc);
    check("s1_init_latency", 256'(cyc), 256'(L + 2));
    for (int i = 1; i <= 11; i++) begin
      get_block($sformatf("s1_b%0d", i), 1'b0);
      if (i == 2) entropy = 256'hc0ffee00_12345678_9abcdef0_0badf00d_deadbeef_55aa55aa_01020304_a5a5a5a5;
      if (i == 9) check("s1_init_rises", 256'(init_rises - rise_base), 256'd3);
    end

    // master, entropy 1: next_seed must be ignored everywhere
    do_reset("s2_rst", 1'b1, 256'd1);
    get_block("s2_b1", 1'b0);
    get_block("s2_b2", 1'b1);
    get_block("s2_b3", 1'b0);
    get_block("s2_b4", 1'b0);
    wait_init("s2_pre_pulse", cyc);
    @(negedge clk) next_seed = 1'b1;
    @(negedge clk) next_seed = 1'b0;
    check("s2_pulse_ignored", 256'(init_ready), 256'd1);
    get_block("s2_b5", 1'b0);

    // slave, entropy 1: same start as master, then forced reseeds
    do_reset("s3_rst", 1'b0, 256'd1);
    get_block("s3_b1", 1'b0);
    wait_init("s3_pre_pulse", cyc);
    @(negedge clk) next_seed = 1'b1;
    @(negedge clk) next_seed = 1'b0;
    check("s3_pulse_drops_init", 256'(init_ready), 256'd0);
    m_seed();
    get_block("s3_b2", 1'b1);
    get_block("s3_b3", 1'b0);
    get_block("s3_b4", 1'b0);

`ifdef MSH_DRBG_CATCH_UP_EN
    do_reset("s4_rst", 1'b0, 256'd0);
    wait_init("s4", cyc);
    @(negedge clk) catch_up_mode = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (next_bits_ready) cnt++;
      if (cnt == 6) catch_up_mode = 1'b0;
    end
    catch_up_mode = 1'b0;
    check("s4_catch_up_blocks", 256'(cnt), 256'd6);
    for (int i = 0; i < 6; i++) begin
      m_block();
      m_after_ack(1'b0);
    end
    wait_init("s4_after", cyc);
    check("s4_reseed_cnt", 256'(reseed_counter), 256'd3);
    check("s4_last_bits", random_bits, m_last);
    get_block("s4_b7", 1'b0);
`else
    do_reset("s4_rst", 1'b0, 256'd0);
    wait_init("s4", cyc);
    @(negedge clk) catch_up_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (next_bits_ready) cnt++;
    end
    catch_up_mode = 1'b0;
    check("s4_no_ack", 256'(cnt), 256'd0);
    check("s4_bits_idle", random_bits, 256'd0);
    check("s4_reseed_cnt", 256'(reseed_counter), 256'(m_reseed));
`endif

    // reset asserted in the middle of a block hash, then identical restart
    do_reset("s5_rst", 1'b0, 256'h5);
    get_block("s5_b1", 1'b0);
    @(negedge clk) next_bits = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("s5_async");
    next_bits = 1'b0;
    do_reset("s5_rst2", 1'b0, 256'h5);
    get_block("s5_r1", 1'b0);
    get_block("s5_r2", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/master_slave_hash_drbg.md
# master_slave_hash_drbg

Two-level hash DRBG for the video scrambler key stream. A seed generator (master hash chain) derives seeds from a 256-bit entropy word; a bits generator (slave hash chain) expands each seed into a bounded number of 256-bit random blocks. Master and slave scrambler ends run identical instances from the same entropy, so both produce the same stream; the slave end can force resync and fast-forward.

## Interface
- SEED_GENERATOR_MAX_CYCLE, 3: seeds derived before the seed chain re-ingests `entropy`
- BITS_GENERATOR_MAX_CYCLE, 3: random blocks per seed before the bits chain is reseeded
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- is_master_mode  in  1  1 = master, 0 = slave
- next_seed  in  1  slave only: single-cycle pulse forcing an immediate reseed; ignored in master mode
- next_bits  in  1  four-phase request for one random block
- catch_up_mode  in  1  slave only: generate and discard blocks without a request
- entropy  in  256  entropy or initial seed, sampled at defined points
- init_ready  out  1  bits generator holds a valid seed
- next_bits_ready  out  1  `random_bits` valid, four-phase acknowledge
- random_bits  out  256  current random block
- reseed_counter  out  64  number of seeds loaded into the bits generator since reset

## Operation
- H(x) = SHA-256 of the 256-bit message x, single padded block.
- State: V_s (256), V_b (256), seed_cnt, bits_cnt, reseed_counter.
- FSM states: IDLE, LOAD_ENTROPY, SEED_HASH, READY, BITS_HASH, ACK.
- IDLE: entered after reset. Moves to LOAD_ENTROPY on the first clock after reset_n goes high.
- LOAD_ENTROPY: V_s <= entropy. seed_cnt <= 0.
- SEED_HASH: S = H(V_s).
  - V_b <= S.
  - V_s <= V_s + S + seed_cnt, mod 2^256.
  - seed_cnt++, bits_cnt <= 0, reseed_counter++.
  - init_ready <= 1, then go to READY.
- READY: when next_bits = 1 (or catch_up_mode = 1 in slave mode), go to BITS_HASH.
- BITS_HASH: R = H(V_b).
  - random_bits <= R.
  - V_b <= V_b + R + 1, mod 2^256.
  - bits_cnt++.
  - Then go to ACK.
- ACK: next_bits_ready = 1 and held until next_bits = 0. In catch-up this phase lasts one cycle.
- Leaving ACK:
  - If bits_cnt == BITS_GENERATOR_MAX_CYCLE: init_ready <= 0.
    - If seed_cnt == SEED_GENERATOR_MAX_CYCLE, go to LOAD_ENTROPY (re-ingest `entropy`).
    - Otherwise go to SEED_HASH.
  - Otherwise go to READY.
- next_seed pulse, slave mode, any state except a running hash: abandon the current seed and go to SEED_HASH (forced reseed).
- A next_seed arriving during a hash is latched and acted on when that hash finishes.
- A next_bits request is ignored until init_ready = 1.
- A new block needs next_bits low and then high again (four-phase handshake).

## Timing
- Reset values: init_ready 0, next_bits_ready 0, random_bits 0, reseed_counter 0. All internal state is also 0.
- Hash latency is L cycles, fixed by the core.
  - init_ready rises L+2 cycles after reset release.
  - next_bits_ready rises L+1 cycles after next_bits is sampled high.
- Reseed gap: init_ready stays low for L+1 cycles, or L+2 when entropy is re-ingested.
- random_bits holds its value until the next BITS_HASH completes.
- Reset asserted mid-hash aborts immediately: the core is reset and all outputs return to their reset values.

## Configuration
- MSH_DRBG_CATCH_UP_EN defined: catch_up_mode behaves as described in Operation.
- MSH_DRBG_CATCH_UP_EN undefined: catch_up_mode is ignored and blocks are generated only on next_bits.

## Structure
- Shared package msh_drbg_pkg holds:
  - the state enum;
  - the widths: HASH_W=256, CNT_W=64;
  - the message padding constant for a 256-bit single block.
- One sub-module, sha256_block: start/busy/done handshake, 256-bit message in, 256-bit digest out.
- A single sha256_block instance is time-shared between the two chains.

## Test plan
- Slave mode, entropy=0, next_seed=0, four-phase next_bits for 9 blocks -> 9 acknowledges; init_ready rises exactly 3 times; reseed_counter reads 1, 2, 3; blocks match the software model.
- Master and slave instances, same entropy 256'h1 -> identical random_bits sequences and reseed_counter values.
- Slave next_seed pulse after block 1 -> init_ready falls, reseed_counter +1, next block = H(V_b) of the new seed.
- Catch-up (macro on), slave, catch_up_mode high for 6 blocks with next_bits=0 -> reseed_counter = 3, no next_bits_ready held, later blocks equal master's blocks 7+.
- Entropy change after 3 seeds -> the 4th seed is derived from the new entropy; before that, changes have no effect.
- reset_n low during BITS_HASH -> all outputs 0 asynchronously; after release, the sequence restarts identically.
